// File: rtl/poly94_fb_pkg.sv
// Shared framebuffer definitions: display geometry, burst limits, pixel type,
// fill FSM state encoding and the row-address helper. The video controller
// imports this package too, so both sides agree on the address layout.
package poly94_fb_pkg;

    localparam int DISPLAY_W  = 320;
    localparam int DISPLAY_H  = 240;
    localparam int BURST_LEN  = 64;
    localparam int BURST_BITS = 7;

    localparam logic [5:0] FB_PAGE_DEFAULT = 6'h20;

    typedef logic [15:0] rgb565_t;

    typedef enum logic [2:0] {
        IDLE,
        ROW,
        REQ,
        BURST,
        ACK,
        FINISH
    } fb_state_t;

    // y*320 + x without a multiplier: 320 = 256 + 64.
    function automatic logic [17:0] fb_row_addr(input logic [7:0] y, input logic [8:0] x);
        return ({10'd0, y} << 8) + ({10'd0, y} << 6) + {9'd0, x};
    endfunction

endpackage

// File: rtl/fb_rect_fill_if.sv
// SDRAM burst-write port bundle.
//   master: sdram_wr (request level), sdram_ack (burst close pulse),
//           sdram_addr_x16, sdram_len, sdram_wdata
//   slave : sdram_rdy (one word accepted this cycle)
interface fb_rect_fill_if;
    import poly94_fb_pkg::*;

    logic                  sdram_wr;
    logic                  sdram_rdy;
    logic                  sdram_ack;
    logic [23:0]           sdram_addr_x16;
    logic [BURST_BITS-1:0] sdram_len;
    rgb565_t               sdram_wdata;

    modport master (
        output sdram_wr, sdram_ack, sdram_addr_x16, sdram_len, sdram_wdata,
        input  sdram_rdy
    );

    modport slave (
        input  sdram_wr, sdram_ack, sdram_addr_x16, sdram_len, sdram_wdata,
        output sdram_rdy
    );

endinterface

// File: rtl/fb_burst_wr_port.sv
// Generic SDRAM burst-write handshake engine.
//   start_i      : load addr_i/len_i and raise the write request
//   addr_i/len_i : burst start word address and length (1..BURST_LEN)
//   wdata_i      : write data, presented unchanged on the bus
//   burst_done_o : high in the cycle whose rdy completes the burst
//   bus          : SDRAM write port (master side)
module fb_burst_wr_port
    import poly94_fb_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [23:0]           addr_i,
    input  logic [BURST_BITS-1:0] len_i,
    input  rgb565_t               wdata_i,
    output logic                  burst_done_o,
    fb_rect_fill_if.master        bus
);

    logic                  wr_q;
    logic                  ack_q;
    logic [23:0]           addr_q;
    logic [BURST_BITS-1:0] len_q;
    logic [BURST_BITS-1:0] cnt_q;
    logic [BURST_BITS-1:0] cnt_nxt;
    logic                  word_ok;

    assign cnt_nxt      = cnt_q + 1'b1;
    // rdy only counts while the request is up; during the ack cycle wr is low.
    assign word_ok      = wr_q && bus.sdram_rdy;
    assign burst_done_o = word_ok && (cnt_nxt == len_q);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_q   <= 1'b0;
            ack_q  <= 1'b0;
            addr_q <= '0;
            len_q  <= '0;
            cnt_q  <= '0;
        end else begin
            ack_q <= 1'b0;
            if (start_i) begin
                wr_q   <= 1'b1;
                addr_q <= addr_i;
                len_q  <= len_i;
                cnt_q  <= '0;
            end else if (word_ok) begin
                if (burst_done_o) begin
                    wr_q  <= 1'b0;
                    ack_q <= 1'b1;
                end else begin
                    cnt_q <= cnt_nxt;
                end
            end
        end
    end

    assign bus.sdram_wr       = wr_q;
    assign bus.sdram_ack      = ack_q;
    assign bus.sdram_addr_x16 = addr_q;
    assign bus.sdram_len      = len_q;
    assign bus.sdram_wdata    = wdata_i;

    a_ack_not_wr: assert property (@(posedge clk_i) disable iff (rst_i)
        !(bus.sdram_ack && bus.sdram_wr));

endmodule

// File: rtl/fb_rect_fill.sv
// Rectangle fill engine: writes a constant RGB565 colour into a rectangle of
// the 320x240 framebuffer using row-bounded SDRAM bursts.
//   clk_i, rst_i         : clock, synchronous active-high reset
//   start_i              : command strobe (ignored while busy_o)
//   fb_page_i            : framebuffer page (word address bits 23:18)
//   x_i, y_i, w_i, h_i   : rectangle origin and size
//   color_i              : fill colour
//   busy_o, done_o, err_o: status; done_o/err_o are one-cycle pulses
//   sdram                : SDRAM write port (master side)
//
// state  | meaning
// IDLE   | waiting for start_i
// ROW    | compute row start address, reload remaining width
// REQ    | launch a burst of min(remaining, BURST_LEN) words
// BURST  | words streaming, waiting for the last rdy
// ACK    | ack cycle; pick next burst, next row, or finish
// FINISH | report completion (and rejection) to the CPU
module fb_rect_fill
    import poly94_fb_pkg::*;
(
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           start_i,
    input  logic [5:0]     fb_page_i,
    input  logic [8:0]     x_i,
    input  logic [7:0]     y_i,
    input  logic [8:0]     w_i,
    input  logic [7:0]     h_i,
    input  rgb565_t        color_i,
    output logic           busy_o,
    output logic           done_o,
    output logic           err_o,
    fb_rect_fill_if.master sdram
);

    fb_state_t             state_q, state_d;
    logic [5:0]            page_q;
    logic [8:0]            x_q;
    logic [7:0]            y_q;
    logic [8:0]            w_q;
    logic [7:0]            rows_q;
    rgb565_t               color_q;
    logic                  rej_q;
    logic [17:0]           row_addr_q;
    logic [8:0]            remain_q;
    logic                  done_q;
    logic                  err_q;

    logic                  empty_cmd;
    logic                  fits;
    logic                  cmd_start;
    logic                  burst_done;
    logic [BURST_BITS-1:0] burst_len;

    assign empty_cmd = (w_i == '0) || (h_i == '0);
    // Widened sums so e.g. x=300,w=255 cannot wrap into range.
    assign fits = (({1'b0, x_i} + {1'b0, w_i}) <= 10'(DISPLAY_W)) &&
                  (({1'b0, y_i} + {1'b0, h_i}) <= 9'(DISPLAY_H));

    always_comb begin
        burst_len = remain_q[BURST_BITS-1:0];
        if (remain_q >= 9'(BURST_LEN)) begin
            burst_len = BURST_BITS'(BURST_LEN);
        end
    end

    always_comb begin
        state_d   = state_q;
        cmd_start = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = (empty_cmd || !fits) ? FINISH : ROW;
                end
            end
            ROW:   state_d = REQ;
            REQ: begin
                cmd_start = 1'b1;
                state_d   = BURST;
            end
            BURST: begin
                if (burst_done) begin
                    state_d = ACK;
                end
            end
            ACK: begin
                if (remain_q != '0) begin
                    state_d = REQ;
                end else if (rows_q > 8'd1) begin
                    state_d = ROW;
                end else begin
                    state_d = FINISH;
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            page_q     <= '0;
            x_q        <= '0;
            y_q        <= '0;
            w_q        <= '0;
            rows_q     <= '0;
            color_q    <= '0;
            rej_q      <= 1'b0;
            row_addr_q <= '0;
            remain_q   <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= (state_q == FINISH);
            err_q   <= (state_q == FINISH) && rej_q;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        page_q  <= fb_page_i;
                        x_q     <= x_i;
                        y_q     <= y_i;
                        w_q     <= w_i;
                        rows_q  <= h_i;
                        color_q <= color_i;
                        rej_q   <= !empty_cmd && !fits;
                    end
                end
                ROW: begin
                    row_addr_q <= fb_row_addr(y_q, x_q);
                    remain_q   <= w_q;
                end
                BURST: begin
                    if (burst_done) begin
                        row_addr_q <= row_addr_q + {11'd0, burst_len};
                        remain_q   <= remain_q - {2'd0, burst_len};
                    end
                end
                ACK: begin
                    if ((remain_q == '0) && (rows_q > 8'd1)) begin
                        y_q    <= y_q + 8'd1;
                        rows_q <= rows_q - 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy_o = (state_q != IDLE);
    assign done_o = done_q;
    assign err_o  = err_q;

    fb_burst_wr_port u_port (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .start_i      (cmd_start),
        .addr_i       ({page_q, row_addr_q}),
        .len_i        (burst_len),
        .wdata_i      (color_q),
        .burst_done_o (burst_done),
        .bus          (sdram)
    );

endmodule
